// File: rtl/mem_stage_pipelined.sv
// rtl/mem_stage_pipelined.sv - MEM pipeline stage: word/half/byte load/store against an internal RAM
// Ops are held in a pending slot until their latency elapses, then registered to MEM/WB.
module mem_stage_pipelined #(
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = 1,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_write_back,
  input  logic                  in_mem_to_reg,
  input  logic [1:0]            in_load_mode,
  input  logic                  in_load_unsigned,
  input  logic [31:0]           in_address,
  input  logic [31:0]           in_write_data,
  input  logic [REG_ADDR_W-1:0] in_dest_reg,
  output logic                  out_valid,
  output logic                  write_back_out,
  output logic                  mem_to_reg_out,
  output logic [31:0]           read_data,
  output logic [31:0]           address_out,
  output logic [REG_ADDR_W-1:0] dest_reg_out,
  output logic                  misaligned_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_next;
  logic [3:0]              count, count_next;
  logic [31:0]             ram [DEPTH_WORDS];

  logic                    p_valid, p_read, p_write, p_wb, p_m2r, p_uns;
  logic [1:0]              p_mode;
  logic [31:0]             p_addr, p_wdata;
  logic [REG_ADDR_W-1:0]   p_dest;

  logic                    accept, complete, in_mem, misaligned, do_write, is_load;
  logic [AW-1:0]           idx;
  logic [31:0]             word, ext, lane_data;
  logic [15:0]             half_sel;
  logic [7:0]              byte_sel;
  logic [3:0]              byte_en;

  assign in_mem   = in_mem_read || in_mem_write;
  assign accept   = in_valid && in_ready;
  assign complete = p_valid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (accept && in_mem && (MEM_LATENCY > 1)) begin
          state_next = BUSY;
          count_next = 4'(MEM_LATENCY - 1);
        end
      end
      BUSY: begin
        count_next = count - 4'd1;
        if (count == 4'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && !rst;
  end

  // Mode 11 behaves as a word; store takes precedence when both read and write are set.
  always_comb begin
    idx        = p_addr[AW+1:2];
    word       = ram[idx];
    is_load    = p_read && !p_write;
    misaligned = 1'b0;
    ext        = word;
    half_sel   = p_addr[1] ? word[31:16] : word[15:0];
    byte_sel   = word[7:0];
    byte_en    = 4'hF;
    lane_data  = p_wdata;
    case (p_addr[1:0])
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    case (p_mode)
      2'b01: begin
        misaligned = p_addr[0];
        ext        = p_uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        byte_en    = p_addr[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{p_wdata[15:0]}};
      end
      2'b10: begin
        ext        = p_uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        byte_en    = 4'b0001 << p_addr[1:0];
        lane_data  = {4{p_wdata[7:0]}};
      end
      default: misaligned = (p_addr[1:0] != 2'b00);
    endcase
    misaligned = misaligned && (p_read || p_write);
    do_write   = complete && p_write && !misaligned && !rst;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (do_write && byte_en[i]) ram[idx][8*i +: 8] <= lane_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid        <= 1'b0;
      p_read         <= 1'b0;
      p_write        <= 1'b0;
      p_wb           <= 1'b0;
      p_m2r          <= 1'b0;
      p_uns          <= 1'b0;
      p_mode         <= 2'b00;
      p_addr         <= 32'h0;
      p_wdata        <= 32'h0;
      p_dest         <= '0;
      out_valid      <= 1'b0;
      write_back_out <= 1'b0;
      mem_to_reg_out <= 1'b0;
      read_data      <= 32'h0;
      address_out    <= 32'h0;
      dest_reg_out   <= '0;
      misaligned_out <= 1'b0;
    end else begin
      out_valid <= complete;
      if (complete) begin
        write_back_out <= p_wb && !p_write && !misaligned;
        mem_to_reg_out <= p_m2r;
        read_data      <= (is_load && !misaligned) ? ext : 32'h0;
        address_out    <= p_addr;
        dest_reg_out   <= p_dest;
        misaligned_out <= misaligned;
      end
      if (accept) begin
        p_valid <= 1'b1;
        p_read  <= in_mem_read;
        p_write <= in_mem_write;
        p_wb    <= in_write_back;
        p_m2r   <= in_mem_to_reg;
        p_uns   <= in_load_unsigned;
        p_mode  <= in_load_mode;
        p_addr  <= in_address;
        p_wdata <= in_write_data;
        p_dest  <= in_dest_reg;
      end else if (complete) begin
        p_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// tb/tb_mem_stage_pipelined.sv - three configurations checked each cycle against a byte-level model
module tb_mem_stage_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic        in_valid [3], in_ready [3], in_mem_read [3], in_mem_write [3];
  logic        in_write_back [3], in_mem_to_reg [3], in_load_unsigned [3];
  logic [1:0]  in_load_mode [3];
  logic [31:0] in_address [3], in_write_data [3];
  logic [4:0]  in_dest_reg [3];
  logic        out_valid [3], write_back_out [3], mem_to_reg_out [3], misaligned_out [3];
  logic [31:0] read_data [3], address_out [3];
  logic [4:0]  dest_reg_out [3];
  logic        lit_en [3];
  logic [31:0] lit_val [3];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int ML = (g == 1) ? 4 : ((g == 2) ? 3 : 1);
      localparam int DW = (g == 2) ? 16 : 256;
      mem_stage_pipelined #(.DEPTH_WORDS(DW), .MEM_LATENCY(ML), .REG_ADDR_W(5)) u_dut (
        .clk(clk), .rst(rst[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
        .in_mem_read(in_mem_read[g]), .in_mem_write(in_mem_write[g]),
        .in_write_back(in_write_back[g]), .in_mem_to_reg(in_mem_to_reg[g]),
        .in_load_mode(in_load_mode[g]), .in_load_unsigned(in_load_unsigned[g]),
        .in_address(in_address[g]), .in_write_data(in_write_data[g]),
        .in_dest_reg(in_dest_reg[g]), .out_valid(out_valid[g]),
        .write_back_out(write_back_out[g]), .mem_to_reg_out(mem_to_reg_out[g]),
        .read_data(read_data[g]), .address_out(address_out[g]),
        .dest_reg_out(dest_reg_out[g]), .misaligned_out(misaligned_out[g])
      );
    end
  endgenerate

  function automatic int lat(int g);
    return (g == 1) ? 4 : ((g == 2) ? 3 : 1);
  endfunction

  function automatic int depth(int g);
    return (g == 2) ? 16 : 256;
  endfunction

  typedef struct {
    bit          rd, wr, wb, m2r, uns, le;
    logic [1:0]  mode;
    logic [31:0] a, wd, lv;
    logic [4:0]  dst;
  } op_t;

  // Model: byte-addressed memory, one pending op with its completion edge index.
  int          edges = 0;
  int          free_edge [3];
  int          done_edge [3];
  bit          pend [3];
  op_t         pop [3];
  logic [7:0]  mb [3][1024];
  bit          e_valid [3], e_wb [3], e_m2r [3], e_mis [3], e_le [3];
  logic [31:0] e_rd [3], e_addr [3], e_lv [3];
  logic [4:0]  e_dst [3];
  bit          chk_on = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic model_complete(int g);
    op_t         o;
    int          sz, nb, ba;
    bit          mem, mis;
    logic [31:0] val;
    o   = pop[g];
    nb  = 4 * depth(g);
    ba  = int'(o.a & 32'(nb - 1));
    sz  = (o.mode == 2'b01) ? 2 : ((o.mode == 2'b10) ? 1 : 4);
    mem = o.rd || o.wr;
    mis = mem && ((ba % sz) != 0);
    val = 32'h0;
    if (mem && !mis) begin
      if (o.wr) begin
        for (int i = 0; i < sz; i++) mb[g][ba + i] = o.wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) val = val | ({24'h0, mb[g][ba + i]} << (8 * i));
        if (!o.uns && sz < 4 && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8 * sz));
      end
    end
    e_valid[g] = 1'b1;
    e_rd[g]    = val;
    e_wb[g]    = o.wb && !o.wr && !mis;
    e_m2r[g]   = o.m2r;
    e_mis[g]   = mis;
    e_addr[g]  = o.a;
    e_dst[g]   = o.dst;
    e_le[g]    = o.le;
    e_lv[g]    = o.lv;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      free_edge[g] = 0; done_edge[g] = 0; pend[g] = 1'b0;
      e_valid[g] = 0; e_wb[g] = 0; e_m2r[g] = 0; e_mis[g] = 0; e_le[g] = 0;
      e_rd[g] = 0; e_addr[g] = 0; e_dst[g] = 0; e_lv[g] = 0;
    end
    forever begin
      @(posedge clk);
      for (int g = 0; g < 3; g++) begin
        e_valid[g] = 1'b0;
        e_le[g]    = 1'b0;
        if (rst[g]) begin
          pend[g] = 1'b0; free_edge[g] = edges + 1;
          e_wb[g] = 0; e_m2r[g] = 0; e_mis[g] = 0; e_rd[g] = 0; e_addr[g] = 0; e_dst[g] = 0;
        end else begin
          if (pend[g] && done_edge[g] == edges) begin
            model_complete(g);
            pend[g] = 1'b0;
          end
          if (in_valid[g] && edges >= free_edge[g]) begin
            pop[g] = '{rd: in_mem_read[g], wr: in_mem_write[g], wb: in_write_back[g],
                       m2r: in_mem_to_reg[g], uns: in_load_unsigned[g], le: lit_en[g],
                       mode: in_load_mode[g], a: in_address[g], wd: in_write_data[g],
                       lv: lit_val[g], dst: in_dest_reg[g]};
            pend[g] = 1'b1;
            if (in_mem_read[g] || in_mem_write[g]) begin
              done_edge[g] = edges + lat(g);
              free_edge[g] = edges + lat(g);
            end else begin
              done_edge[g] = edges + 1;
              free_edge[g] = edges + 1;
            end
          end
        end
      end
      edges = edges + 1;
    end
  end

  task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s[inst %0d] t=%0t got %h want %h", nm, g, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int g = 0; g < 3; g++) begin
          chk("in_ready", g, {31'h0, in_ready[g]}, {31'h0, !rst[g] && edges >= free_edge[g]});
          chk("out_valid", g, {31'h0, out_valid[g]}, {31'h0, e_valid[g]});
          chk("write_back_out", g, {31'h0, write_back_out[g]}, {31'h0, e_wb[g]});
          chk("mem_to_reg_out", g, {31'h0, mem_to_reg_out[g]}, {31'h0, e_m2r[g]});
          chk("misaligned_out", g, {31'h0, misaligned_out[g]}, {31'h0, e_mis[g]});
          chk("read_data", g, read_data[g], e_rd[g]);
          chk("address_out", g, address_out[g], e_addr[g]);
          chk("dest_reg_out", g, {27'h0, dest_reg_out[g]}, {27'h0, e_dst[g]});
          if (e_valid[g] && e_le[g]) begin
            chk("lit_read_data", g, read_data[g], e_lv[g]);
            chk("model_pin", g, e_rd[g], e_lv[g]);
          end
        end
      end
    end
  end

  task automatic issue(int g, bit rd, bit wr, bit wb, bit m2r, logic [1:0] mode, bit uns,
                       logic [31:0] a, logic [31:0] wd, logic [4:0] dst, bit le, logic [31:0] lv);
    in_mem_read[g] = rd; in_mem_write[g] = wr; in_write_back[g] = wb; in_mem_to_reg[g] = m2r;
    in_load_mode[g] = mode; in_load_unsigned[g] = uns; in_address[g] = a;
    in_write_data[g] = wd; in_dest_reg[g] = dst; lit_en[g] = le; lit_val[g] = lv;
    in_valid[g] = 1'b1;
    while (edges < free_edge[g]) @(negedge clk);
    @(negedge clk);
    in_valid[g] = 1'b0;
    lit_en[g] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; in_valid[g] = 0; in_mem_read[g] = 0; in_mem_write[g] = 0;
      in_write_back[g] = 0; in_mem_to_reg[g] = 0; in_load_mode[g] = 0; in_load_unsigned[g] = 0;
      in_address[g] = 0; in_write_data[g] = 0; in_dest_reg[g] = 0; lit_en[g] = 0; lit_val[g] = 0;
    end
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;
    @(negedge clk);

    // Latency 1: store/load, sub-word, misaligned, non-memory, store-wins.
    issue(0, 0, 1, 0, 0, 2'b00, 0, 32'h40, 32'hDEADBEEF, 5'd1, 0, 32'h0);
    issue(0, 1, 0, 1, 1, 2'b00, 0, 32'h40, 32'h0, 5'd2, 1, 32'hDEADBEEF);
    issue(0, 0, 1, 0, 0, 2'b10, 0, 32'h41, 32'h12345680, 5'd3, 0, 32'h0);
    issue(0, 1, 0, 1, 1, 2'b10, 0, 32'h41, 32'h0, 5'd4, 1, 32'hFFFFFF80);
    issue(0, 1, 0, 1, 1, 2'b10, 1, 32'h41, 32'h0, 5'd5, 1, 32'h00000080);
    issue(0, 1, 0, 1, 1, 2'b01, 0, 32'h42, 32'h0, 5'd6, 1, 32'hFFFFDEAD);
    issue(0, 1, 0, 1, 1, 2'b01, 1, 32'h42, 32'h0, 5'd6, 1, 32'h0000DEAD);
    issue(0, 0, 1, 0, 0, 2'b00, 0, 32'h44, 32'hCAFEF00D, 5'd7, 0, 32'h0);
    issue(0, 1, 0, 1, 1, 2'b00, 0, 32'h43, 32'h0, 5'd8, 1, 32'h0);
    issue(0, 0, 1, 0, 0, 2'b01, 0, 32'h45, 32'h00005555, 5'd9, 0, 32'h0);
    issue(0, 1, 0, 1, 1, 2'b11, 0, 32'h44, 32'h0, 5'd10, 1, 32'hCAFEF00D);
    issue(0, 0, 0, 1, 0, 2'b00, 0, 32'h1233, 32'h0, 5'd11, 1, 32'h0);
    issue(0, 1, 1, 1, 1, 2'b01, 0, 32'h46, 32'h0000BEEF, 5'd12, 1, 32'h0);
    issue(0, 1, 0, 1, 1, 2'b00, 0, 32'h44, 32'h0, 5'd13, 1, 32'hBEEFF00D);
    repeat (3) @(negedge clk);

    // Latency 4: back-to-back loads, then a non-memory op.
    issue(1, 0, 1, 0, 0, 2'b00, 0, 32'h10, 32'h11223344, 5'd1, 0, 32'h0);
    issue(1, 1, 0, 1, 1, 2'b00, 0, 32'h10, 32'h0, 5'd2, 1, 32'h11223344);
    issue(1, 1, 0, 1, 1, 2'b01, 1, 32'h12, 32'h0, 5'd3, 1, 32'h00001122);
    issue(1, 0, 0, 1, 0, 2'b00, 0, 32'h77, 32'h0, 5'd4, 1, 32'h0);
    issue(1, 1, 0, 1, 1, 2'b10, 0, 32'h13, 32'h0, 5'd5, 1, 32'h00000011);
    repeat (6) @(negedge clk);

    // Depth 16, latency 3: address wrap and reset abort of a pending store.
    issue(2, 0, 1, 0, 0, 2'b00, 0, 32'h40, 32'h12345678, 5'd1, 0, 32'h0);
    issue(2, 1, 0, 1, 1, 2'b00, 0, 32'h00, 32'h0, 5'd2, 1, 32'h12345678);
    repeat (4) @(negedge clk);
    issue(2, 0, 1, 0, 0, 2'b00, 0, 32'h00, 32'hAAAAAAAA, 5'd3, 0, 32'h0);
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    repeat (3) @(negedge clk);
    issue(2, 1, 0, 1, 1, 2'b00, 0, 32'h00, 32'h0, 5'd4, 1, 32'h12345678);
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
